// File: rtl/clk_gen_bank.sv
// Multi-channel divided-clock generator with per-channel programmable half-period
// and a run/step/hold mode for push-button single-stepping.
module clk_gen_bank #(
    parameter int NCH      = 5,
    parameter int CNT_W    = 32,
    parameter int DEF_HALF = 2048000,
    parameter int CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             step_req,
    input  logic [NCH-1:0]   step_en,
    input  logic             restart,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_half,
    output logic [NCH-1:0]   div_clk,
    output logic [NCH-1:0]   tick,
    output logic             step_busy
);

    localparam logic [1:0]       MODE_RUN  = 2'b00;
    localparam logic [1:0]       MODE_STEP = 2'b01;
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO      = '0;
    localparam logic [CNT_W-1:0] RST_HALF  = (DEF_HALF == 0) ? ONE : CNT_W'(DEF_HALF);

    // Push-button synchroniser, previous-level flop and registered edge pulse
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic sync3_q, sync3_d;
    logic edge_q,  edge_d;
    logic busy_q,  busy_d;

    logic             arm_fire;
    logic             cfg_hit;
    logic [CNT_W-1:0] cfg_half_sat;
    logic [NCH-1:0]   armed_next;

    always_comb begin
        sync1_d      = step_req;
        sync2_d      = sync1_q;
        sync3_d      = sync2_q;
        edge_d       = sync2_q & ~sync3_q;
        arm_fire     = edge_q && (mode == MODE_STEP) && !busy_q;
        cfg_hit      = cfg_we && (int'(cfg_ch) < NCH);
        cfg_half_sat = (cfg_half == ZERO) ? ONE : cfg_half;
        busy_d       = |armed_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            edge_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sync3_q <= sync3_d;
            edge_q  <= edge_d;
            busy_q  <= busy_d;
        end
    end

    assign step_busy = busy_q;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [CNT_W-1:0] half_q, half_d;
            logic [CNT_W-1:0] cnt_q,  cnt_d;
            logic             div_q,  div_d;
            logic             tick_q, tick_d;
            logic             armed_q, armed_d;
            logic             seen_q, seen_d;
            logic             wr_sel;
            logic             adv;
            logic             wrap;

            always_comb begin
                wr_sel  = cfg_hit && (cfg_ch == CH_W'(gi));
                adv     = (mode == MODE_RUN) || ((mode == MODE_STEP) && armed_q);
                wrap    = (cnt_q == half_q - ONE);
                half_d  = wr_sel ? cfg_half_sat : half_q;
                cnt_d   = cnt_q;
                div_d   = div_q;
                tick_d  = 1'b0;
                armed_d = armed_q;
                seen_d  = seen_q;
                if (restart) begin
                    cnt_d   = ZERO;
                    div_d   = 1'b0;
                    armed_d = 1'b0;
                    seen_d  = 1'b0;
                end else if (wr_sel) begin
                    cnt_d   = ZERO;
                    div_d   = 1'b0;
                    armed_d = 1'b0;
                end else begin
                    if (adv) begin
                        if (wrap) begin
                            cnt_d  = ZERO;
                            div_d  = ~div_q;
                            tick_d = ~div_q;
                            // A step ends on the first fall after its rise was seen
                            if (armed_q) begin
                                if (!div_q) begin
                                    seen_d = 1'b1;
                                end else if (seen_q) begin
                                    armed_d = 1'b0;
                                end
                            end
                        end else begin
                            cnt_d = cnt_q + ONE;
                        end
                    end
                    if (arm_fire && step_en[gi]) begin
                        armed_d = 1'b1;
                        seen_d  = 1'b0;
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    half_q  <= RST_HALF;
                    cnt_q   <= ZERO;
                    div_q   <= 1'b0;
                    tick_q  <= 1'b0;
                    armed_q <= 1'b0;
                    seen_q  <= 1'b0;
                end else begin
                    half_q  <= half_d;
                    cnt_q   <= cnt_d;
                    div_q   <= div_d;
                    tick_q  <= tick_d;
                    armed_q <= armed_d;
                    seen_q  <= seen_d;
                end
            end

            assign armed_next[gi] = armed_d;
            assign div_clk[gi]    = div_q;
            assign tick[gi]       = tick_q;
        end
    endgenerate

endmodule

// File: tb/tb_clk_gen_bank.sv
// Scoreboard bench for clk_gen_bank: expected per-edge outputs come from a phase
// count per channel (div = (phase/half) mod 2, tick when phase mod 2*half == half).
module tb_clk_gen_bank;

    localparam int NCH   = 3;
    localparam int CNT_W = 8;
    localparam int CH_W  = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [1:0]       mode = 2'b00;
    logic             step_req = 1'b0;
    logic [NCH-1:0]   step_en = '0;
    logic             restart = 1'b0;
    logic             cfg_we = 1'b0;
    logic [CH_W-1:0]  cfg_ch = '0;
    logic [CNT_W-1:0] cfg_half = '0;
    logic [NCH-1:0]   div_clk;
    logic [NCH-1:0]   tick;
    logic             step_busy;

    clk_gen_bank #(
        .NCH      (NCH),
        .CNT_W    (CNT_W),
        .DEF_HALF (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .step_req  (step_req),
        .step_en   (step_en),
        .restart   (restart),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_half  (cfg_half),
        .div_clk   (div_clk),
        .tick      (tick),
        .step_busy (step_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NCH-1:0] dv;
        logic [NCH-1:0] tk;
        logic           bz;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   ph[NCH];
    int   hv[NCH];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
        end
    endtask

    task automatic sample_cycle(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        check_eq({tag, "_sbdepth"}, exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq({tag, "_div"},  div_clk,   e.dv);
            check_eq({tag, "_tick"}, tick,      e.tk);
            check_eq({tag, "_busy"}, step_busy, e.bz);
            $display("%s t=%0t div=%b tick=%b busy=%b", tag, $time, div_clk, tick, step_busy);
        end
    endtask

    // Advance the phase model by one edge, queue the expectation, then sample.
    task automatic model_edge(input string tag, input logic [NCH-1:0] adv,
                              input logic [NCH-1:0] clr, input logic busy);
        exp_t e;
        for (int ch = 0; ch < NCH; ch++) begin
            e.tk[ch] = 1'b0;
            if (clr[ch]) begin
                ph[ch] = 0;
            end else if (adv[ch]) begin
                ph[ch]   = ph[ch] + 1;
                e.tk[ch] = ((ph[ch] % (2 * hv[ch])) == hv[ch]);
            end
            e.dv[ch] = (((ph[ch] / hv[ch]) % 2) == 1);
        end
        e.bz = busy;
        exp_q.push_back(e);
        sample_cycle(tag);
    endtask

    // step_req pulse sampled first at edge k (i=0): armed after k+3, advancing k+4..k+9.
    task automatic step_seq(input string tag, input bit second, input int n);
        logic [NCH-1:0] adv;
        for (int i = 0; i < n; i++) begin
            step_req = (i < 2) || (second && (i == 5 || i == 6));
            adv      = (i >= 4 && i <= 9) ? step_en : '0;
            model_edge(tag, adv, '0, (i >= 3 && i <= 8));
        end
        step_req = 1'b0;
    endtask

    task automatic model_reset_state();
        for (int ch = 0; ch < NCH; ch++) begin
            ph[ch] = 0;
            hv[ch] = 3;
        end
    endtask

    initial begin
        #2 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("reset_div",  div_clk,   0);
        check_eq("reset_tick", tick,      0);
        check_eq("reset_busy", step_busy, 0);
        rst = 1'b0;
        model_reset_state();

        for (int e = 1; e <= 19; e++) model_edge("run", '1, '0, 1'b0);

        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_half = 8'd0; hv[1] = 1;
        model_edge("cfg_ch1", '1, 3'b010, 1'b0);
        cfg_we = 1'b0;
        for (int e = 0; e < 4; e++) model_edge("run_h1", '1, '0, 1'b0);
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_half = 8'd5;
        model_edge("cfg_ch3", '1, '0, 1'b0);
        cfg_we = 1'b0;
        for (int e = 0; e < 6; e++) model_edge("run_after3", '1, '0, 1'b0);

        mode = 2'b10; step_en = '1; step_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) step_req = 1'b0;
            model_edge("hold", '0, '0, 1'b0);
        end
        mode = 2'b00;
        for (int i = 0; i < 10; i++) begin
            step_req = (i < 2);
            model_edge("resume", '1, '0, 1'b0);
        end
        step_req = 1'b0;

        mode = 2'b01; step_en = 3'b101; restart = 1'b1;
        model_edge("restart_a", '0, '1, 1'b0);
        restart = 1'b0;
        step_seq("step", 1'b0, 14);
        step_seq("step_busy_req", 1'b1, 14);

        mode = 2'b00;
        for (int e = 0; e < 4; e++) model_edge("run_pre", '1, '0, 1'b0);
        restart = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd2; cfg_half = 8'd2; hv[2] = 2;
        model_edge("restart_cfg", '1, '1, 1'b0);
        restart = 1'b0; cfg_we = 1'b0;
        for (int e = 0; e < 8; e++) model_edge("run_post", '1, '0, 1'b0);

        mode = 2'b01; restart = 1'b1;
        model_edge("restart_b", '0, '1, 1'b0);
        restart = 1'b0;
        step_seq("step_pre_rst", 1'b0, 7);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_div",  div_clk,   0);
        check_eq("async_rst_tick", tick,      0);
        check_eq("async_rst_busy", step_busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0; mode = 2'b00; step_en = '0;
        model_reset_state();
        for (int e = 1; e <= 8; e++) model_edge("rerun", '1, '0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
